// File: rtl/rp8_bus_mem_pkg.sv
// rp8 bench memory shared types and limits.
// Pipeline entry layout and parameter bounds.
`define RP8_PIPE_ENT(IW_, DW_) struct packed { \
  logic vld; \
  logic [(IW_)-1:0] id; \
  logic [(DW_)-1:0] dat; \
}

package rp8_bench_pkg;

  localparam int LAT_MAX = 8;
  localparam int STL_MAX = 15;
  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/rp8_bus_mem_if.sv
// rp8 memory bus: request/ack plus read response.
// Master drives requests, slave answers.
interface rp8_bus_mem_if #(
  parameter int DW = 8,
  parameter int AW = 13,
  parameter int IW = 6
) ();

  logic          req;
  logic          wen;
  logic [AW-1:0] adr;
  logic [IW-1:0] wid;
  logic [DW-1:0] wdt;
  logic [DW-1:0] msk;
  logic          ack;
  logic          ren;
  logic [DW-1:0] rdt;
  logic [IW-1:0] rid;

  modport master (
    output req, wen, adr, wid, wdt, msk,
    input  ack, ren, rdt, rid
  );

  modport slave (
    input  req, wen, adr, wid, wdt, msk,
    output ack, ren, rdt, rid
  );

endinterface

// File: rtl/rp8_bus_mem_pipe.sv
// Read response delay line, LAT stages deep.
// Last stage holds id/data while no response.
module rp8_bus_mem_pipe
  import rp8_bench_pkg::*;
#(
  parameter int DW  = 8,
  parameter int IW  = 6,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  logic [IW-1:0] in_id,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  output logic [IW-1:0] out_id,
  output logic [DW-1:0] out_dat
);

  typedef `RP8_PIPE_ENT(IW, DW) ent_t;

  ent_t [LAT-1:0] st;
  ent_t [LAT-1:0] src;

  // Source of each stage: the input or the stage before it
  always_comb begin
    src[0] = '{vld: in_vld, id: in_id, dat: in_dat};
    for (int i = 1; i < LAT; i++) begin
      src[i] = st[i-1];
    end
  end

  // Shift entries; the output stage only loads real responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) begin
        st[i].vld <= src[i].vld;
        if (i != LAT - 1 || src[i].vld) begin
          st[i].id  <= src[i].id;
          st[i].dat <= src[i].dat;
        end
      end
    end
  end

  assign out_vld = st[LAT-1].vld;
  assign out_id  = st[LAT-1].id;
  assign out_dat = st[LAT-1].dat;

endmodule

// File: rtl/rp8_bus_mem.sv
// rp8 bench memory responder with latency and throttle.
// Masked writes, in-order tagged read responses.
module rp8_bus_mem
  import rp8_bench_pkg::*;
#(
  parameter int DW  = 8,
  parameter int AW  = 13,
  parameter int IW  = 6,
  parameter int LAT = 1,
  parameter int STL = 0
) (
  input logic         clk,
  input logic         rst_n,
  rp8_bus_mem_if.slave bus
);

  if (LAT < 1 || LAT > LAT_MAX) begin : g_lat_chk
    $error("rp8_bus_mem: LAT=%0d out of range 1..%0d",
           LAT, LAT_MAX);
  end

  if (STL < 0 || STL > STL_MAX) begin : g_stl_chk
    $error("rp8_bus_mem: STL=%0d out of range 0..%0d",
           STL, STL_MAX);
  end

  localparam cnt_t STL_V = cnt_t'(STL);

  logic [DW-1:0] mem [2**AW];

  cnt_t          cnt;
  logic          acc;
  logic          wr;
  logic          rd;
  logic [DW-1:0] rd_dat;

  assign bus.ack = (cnt == '0);
  assign acc     = bus.req & bus.ack;
  assign wr      = acc & bus.wen;
  assign rd      = acc & ~bus.wen;
  assign rd_dat  = mem[bus.adr];

  // Masked write into the array; contents survive reset
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[bus.adr] <= (bus.wdt & bus.msk)
                    | (mem[bus.adr] & ~bus.msk);
    end
  end

  // Throttle: hold ack low for STL cycles after each accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (acc) begin
      cnt <= STL_V;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  rp8_bus_mem_pipe #(
    .DW  (DW),
    .IW  (IW),
    .LAT (LAT)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (rd),
    .in_id   (bus.wid),
    .in_dat  (rd_dat),
    .out_vld (bus.ren),
    .out_id  (bus.rid),
    .out_dat (bus.rdt)
  );

endmodule

// File: doc/rp8_bus_mem.md
# rp8_bus_mem

Parametrised synchronous memory responder for rp8 simulation benches. It replaces the fixed single-cycle program and data memories with one block that has configurable width, depth, read latency and request throttling. It implements the rp8 request/acknowledge/read-enable handshake with ID tagging, byte/bit write masking and in-order pipelined read responses. It is instantiated on the program bus (DW=16) and on the data bus (DW=8) to exercise core stall paths.

## Interface
Parameters:
- DW, 8, data width in bits
- AW, 13, address width; memory depth 2**AW words
- IW, 6, request/response ID width
- LAT, 1, read latency in cycles, legal range 1..8
- STL, 0, acknowledge hold-off cycles after each accepted request, legal range 0..15

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  1  request valid
- wen  input  1  write enable (0 means read)
- adr  input  AW  word address
- wid  input  IW  request ID, returned on rid for reads
- wdt  input  DW  write data
- msk  input  DW  write bit mask, 1 means bit written
- ack  output  1  request accepted when req & ack
- ren  output  1  read response valid, one cycle per read
- rdt  output  DW  read data
- rid  output  IW  read response ID

## Operation
- Acceptance: in any cycle with req & ack; ack never depends on req in the same cycle.
- Write accept: mem[adr] <= wdt & msk | mem[adr] & ~msk at the accepting edge; no response.
- Read accept: mem[adr] is sampled at the accepting edge; {id, data} enters a LAT-deep delay line.
- Read after write: a read accepted in the cycle after a write to the same address returns the new data.
- Throttle counter: loaded with STL on every acceptance and decremented to 0; ack = (counter == 0). With STL=0, ack is constantly 1.
- Responses: strictly in acceptance order, with no back-pressure. At most LAT reads are outstanding; the pipeline is fully pipelined and accepts one request per cycle when STL=0.
- Memory array: not reset. Contents are X until written or preloaded by the bench via hierarchical $readmemh on the array named mem.
- Reset: ack=1, ren=0, rdt=0, rid=0, counter=0, all pipeline valid bits cleared.
- Reset mid-operation: in-flight reads are dropped and never reported. Memory contents are retained.
- Address: the full AW bits are used. There is no wrap or aliasing beyond 2**AW.
- Out-of-range parameters: rejected with an elaboration-time $error.

## Timing
- A read accepted in cycle c gives ren=1 with rdt/rid valid in cycle c+LAT, for exactly one cycle.
- LAT=1 reproduces legacy behaviour: response in the next cycle.
- Back-to-back reads in cycles c and c+1 give responses in cycles c+LAT and c+LAT+1.
- Throttling: acceptance in cycle c gives ack=0 in cycles c+1..c+STL and ack=1 in cycle c+STL+1.
- When rst_n deasserts, the first acceptance can occur in the first cycle.
- rdt/rid hold their last value when ren=0.

## Structure
- Package rp8_bench_pkg holds:
  - typedef of the pipeline entry {vld, id, dat}, parametrised through a macro or a parametrised class-free struct per instance
  - localparams LAT_MAX=8 and STL_MAX=15
- One sub-module, rp8_bus_mem_pipe: a LAT-stage valid/ID/data delay line with async active-low clear.
- The top level contains the array, the mask write, the throttle counter and the parameter checks.

## Test plan
- LAT=1, STL=0:
  - write 8'hA5, msk 8'hFF to adr 0x010, then read adr 0x010 with wid 6'h2A in the next cycle -> ren one cycle later, rdt=8'hA5, rid=6'h2A.
  - masked write 8'h0F, msk 8'h3C over 8'hA5 -> subsequent read returns 8'h8D.
- LAT=4, STL=0: reads of adr 1,2,3 in consecutive cycles, ids 1,2,3 -> ren high in cycles c+4..c+6 with ids 1,2,3 in order and matching data.
- STL=3, req held high: ack pattern 1,0,0,0,1,0,0,0; exactly one request accepted every 4 cycles.
- LAT=4: assert rst_n=0 for one cycle while 3 reads are in flight -> no ren afterwards; outputs are 0; memory still returns previously written data.
- DW=16, AW=11, LAT=2, STL=1: preload via $readmemh and read 16 random addresses -> all data matches the file, with responses every 2 cycles.
